// File: rtl/loader_pkg.sv
// Shared types for the MC14500B program loader.
// State encoding and checksum width.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    ERROR
  } loader_state_t;

  localparam int CSUM_W = 8;

endpackage

// File: rtl/loader_checksum.sv
// Byte-fold and XOR accumulator over program words.
// Cleared on start; accumulates on every data beat.
module loader_checksum
  import loader_pkg::*;
#(
  parameter int WORD = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD-1:0]   data,
  output logic [CSUM_W-1:0] fold,
  output logic [CSUM_W-1:0] sum
);

  localparam int NB = (WORD + 7) / 8;

  logic [NB*8-1:0]   ext;
  logic [CSUM_W-1:0] sum_q;
  logic [CSUM_W-1:0] sum_d;

  // Zero-extend the word to whole bytes and XOR the bytes.
  always_comb begin
    ext = '0;
    ext[WORD-1:0] = data;
    fold = '0;
    for (int i = 0; i < NB; i++) begin
      fold = fold ^ ext[i*8 +: 8];
    end
  end

  // Next running value: clear wins over accumulate.
  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (en) begin
      sum_d = sum_q ^ fold;
    end
  end

  // Running checksum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: streams host words into text RAM, then releases the core.
// Optional header checksum check under LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR = 8,
  parameter int CODE = 4,
  parameter int WORD = ADDR + CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD-1:0]   s_data,
  input  logic              s_last,
  output logic              prog_we,
  output logic [ADDR-1:0]   prog_addr,
  output logic [WORD-1:0]   prog_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
`ifdef LOADER_CHECKSUM_EN
  output logic [CSUM_W-1:0] checksum,
`endif
  output logic [ADDR:0]     words_loaded
);

  loader_state_t   state_q, state_d;
  logic [ADDR-1:0] index_q, index_d;
  logic [ADDR:0]   wl_q, wl_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] data_q, data_d;
  logic            beat;
  logic            at_end;
  logic            start_ok;
  logic            csum_bad;
  logic            data_beat;

  assign s_ready  = (state_q == LOAD);
  assign beat     = s_valid & s_ready;
  assign at_end   = (index_q == {ADDR{1'b1}});
  assign start_ok = start & ((state_q == IDLE) |
                             (state_q == RUN) |
                             (state_q == ERROR));

`ifdef LOADER_CHECKSUM_EN
  logic              hdr_q, hdr_d;
  logic [CSUM_W-1:0] exp_q, exp_d;
  logic [CSUM_W-1:0] fold;

  assign data_beat = beat & ~hdr_q;

  loader_checksum #(
    .WORD (WORD)
  ) u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (data_beat),
    .data  (s_data),
    .fold  (fold),
    .sum   (checksum)
  );

  assign csum_bad = ((checksum ^ fold) != exp_q);

  // Header flag and expected checksum capture.
  always_comb begin
    hdr_d = hdr_q;
    exp_d = exp_q;
    if (start_ok) begin
      hdr_d = 1'b1;
    end else if (beat & hdr_q) begin
      hdr_d = 1'b0;
      exp_d = CSUM_W'(s_data);
    end
  end

  // Header state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_q <= 1'b0;
      exp_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      exp_q <= exp_d;
    end
  end
`else
  assign data_beat = beat;
  assign csum_bad  = 1'b0;
`endif

  // Next state, index counter and write port.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE, RUN, ERROR: begin
        if (start_ok) begin
          state_d = LOAD;
          index_d = '0;
          wl_d    = '0;
        end
      end
      LOAD: begin
        if (data_beat) begin
          we_d   = 1'b1;
          addr_d = index_q;
          data_d = s_data;
          wl_d   = wl_q + 1'b1;
          if (!at_end) begin
            index_d = index_q + 1'b1;
          end
          if (s_last) begin
            state_d = csum_bad ? ERROR : FLUSH;
          end else if (at_end) begin
            state_d = ERROR;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign prog_we      = we_q;
  assign prog_addr    = addr_q;
  assign prog_data    = data_q;
  assign words_loaded = wl_q;
  assign cpu_run      = (state_q == RUN);
  assign busy         = (state_q == LOAD) | (state_q == FLUSH);
  assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader.
// Build with LOADER_CHECKSUM_EN to exercise the header checksum path.
module tb_program_loader;

  localparam int ADDR = 8;
  localparam int WORD = 12;

  logic            clk;
  logic            reset;
  logic            start;
  logic            s_valid;
  logic            s_ready;
  logic [WORD-1:0] s_data;
  logic            s_last;
  logic            prog_we;
  logic [ADDR-1:0] prog_addr;
  logic [WORD-1:0] prog_data;
  logic            cpu_run;
  logic            busy;
  logic            error;
  logic [ADDR:0]   words_loaded;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      checksum;
`endif

  int total = 0;
  int bad   = 0;

  logic [ADDR-1:0] wa[$];
  logic [WORD-1:0] wd[$];

  program_loader #(
    .ADDR (ADDR),
    .CODE (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .error        (error),
`ifdef LOADER_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every RAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (prog_we) begin
      wa.push_back(prog_addr);
      wd.push_back(prog_data);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [WORD-1:0] d,
                      input logic l,
                      input int gap);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    int seq_ok;
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (2) tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_we", prog_we, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", error, 0);
    chk("rst_wl", words_loaded, 0);
    reset = 1'b1;
    tick();

`ifdef LOADER_CHECKSUM_EN
    clear_log();
    do_start();
    beat(12'h005, 1'b0, 0);
    chk("hdr_no_we", prog_we, 0);
    beat(12'h001, 1'b0, 0);
    beat(12'h004, 1'b1, 0);
    chk("cs_we", prog_we, 1);
    chk("cs_addr", prog_addr, 1);
    chk("cs_sum", checksum, 8'h05);
    tick();
    chk("cs_run", cpu_run, 1);
    chk("cs_wl", words_loaded, 2);
    chk("cs_nwr", wa.size(), 2);
    do_start();
    beat(12'h006, 1'b0, 0);
    beat(12'h001, 1'b0, 0);
    beat(12'h004, 1'b1, 0);
    chk("csb_we", prog_we, 1);
    chk("csb_addr", prog_addr, 1);
    chk("csb_err", error, 1);
    tick();
    chk("csb_err2", error, 1);
    chk("csb_run", cpu_run, 0);
`else
    clear_log();
    do_start();
    chk("t2_busy", busy, 1);
    chk("t2_ready", s_ready, 1);
    beat(12'h1A5, 1'b0, 0);
    beat(12'h2B6, 1'b0, 0);
    beat(12'h3C7, 1'b1, 0);
    chk("t2_we", prog_we, 1);
    chk("t2_addr", prog_addr, 2);
    chk("t2_data", prog_data, 12'h3C7);
    chk("t2_flush_run", cpu_run, 0);
    chk("t2_flush_rdy", s_ready, 0);
    tick();
    chk("t2_run", cpu_run, 1);
    chk("t2_we_off", prog_we, 0);
    chk("t2_wl", words_loaded, 3);
    tick();
    chk("t2_nwr", wa.size(), 3);
    chk("t2_a0", wa[0], 0);
    chk("t2_a2", wa[2], 2);
    chk("t2_d0", wd[0], 12'h1A5);
    chk("t2_d1", wd[1], 12'h2B6);

    clear_log();
    do_start();
    chk("t3_run0", cpu_run, 0);
    chk("t3_wl0", words_loaded, 0);
    beat(12'h1A5, 1'b0, 2);
    beat(12'h2B6, 1'b0, 2);
    beat(12'h3C7, 1'b1, 2);
    chk("t3_nwr", wa.size(), 3);
    chk("t3_a1", wa[1], 1);
    chk("t3_d2", wd[2], 12'h3C7);
    chk("t3_run", cpu_run, 1);
    chk("t3_wl", words_loaded, 3);

    clear_log();
    do_start();
    beat(12'h111, 1'b0, 0);
    beat(12'h222, 1'b0, 0);
    start = 1'b1;
    beat(12'h333, 1'b0, 0);
    start = 1'b0;
    beat(12'h444, 1'b1, 0);
    tick();
    chk("t5_nwr", wa.size(), 4);
    chk("t5_a3", wa[3], 3);
    chk("t5_wl", words_loaded, 4);
    chk("t5_run", cpu_run, 1);
    s_valid = 1'b1;
    chk("t5_rdy", s_ready, 0);
    repeat (3) tick();
    s_valid = 1'b0;
    chk("t5_nowr", wa.size(), 4);

    clear_log();
    do_start();
    beat(12'h0AA, 1'b0, 0);
    beat(12'h0BB, 1'b0, 0);
    s_valid = 1'b1;
    s_data  = 12'h0CC;
    #6;
    reset = 1'b0;
    #1;
    chk("t1_we", prog_we, 0);
    chk("t1_run", cpu_run, 0);
    chk("t1_busy", busy, 0);
    chk("t1_rdy", s_ready, 0);
    chk("t1_wl", words_loaded, 0);
    chk("t1_addr", prog_addr, 0);
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    s_valid = 1'b1;
    chk("t1_idle_rdy", s_ready, 0);
    repeat (2) tick();
    s_valid = 1'b0;
    chk("t1_idle_busy", busy, 0);
    chk("t1_nwr", wa.size(), 2);

    clear_log();
    do_start();
    for (int i = 0; i < 256; i++) begin
      beat(12'(i) ^ 12'h800, i == 255, 0);
    end
    chk("t4_addr", prog_addr, 255);
    chk("t4_data", prog_data, 12'h8FF);
    tick();
    chk("t4_run", cpu_run, 1);
    chk("t4_wl", words_loaded, 256);
    chk("t4_nwr", wa.size(), 256);
    seq_ok = 1;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] != 8'(i)) seq_ok = 0;
      if (wd[i] != (12'(i) ^ 12'h800)) seq_ok = 0;
    end
    chk("t4_seq", seq_ok, 1);

    clear_log();
    do_start();
    for (int i = 0; i < 256; i++) begin
      beat(12'(i), 1'b0, 0);
    end
    chk("t4o_we", prog_we, 1);
    chk("t4o_addr", prog_addr, 255);
    chk("t4o_err", error, 1);
    chk("t4o_rdy", s_ready, 0);
    chk("t4o_run", cpu_run, 0);
    chk("t4o_wl", words_loaded, 256);
    s_valid = 1'b1;
    repeat (2) tick();
    s_valid = 1'b0;
    chk("t4o_nwr", wa.size(), 256);
    chk("t4o_hold", error, 1);
    do_start();
    chk("t4o_busy", busy, 1);
    chk("t4o_clr", error, 0);
    chk("t4o_wl0", words_loaded, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
